serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//   Parallel-to-serial front end for the serial run-detector FSM. Accepts WIDTH-bit words
//   over a valid/ready handshake and drives them onto the detector's 1-bit input w, one bit
//   per clk cycle, with no gaps unless configured.
//   Sits directly upstream of the detector. Its w output wires straight to the detector's w input.
// PARAMETERS
//   WIDTH       8  bits per word; legal range >= 2
//   MSB_FIRST   0  0: bit 0 goes out first; 1: bit WIDTH-1 goes out first
//   IDLE_LEVEL  0  value driven on w when no word is being shifted
//   GAP_CYCLES  0  idle cycles inserted on w between consecutive words; legal range 0..255
// PORTS
//   clk         in   1      single clock; all state changes on its rising edge
//   rst         in   1      asynchronous reset, active-high
//   in_data     in   WIDTH  word to serialize; sampled only on acceptance
//   in_valid    in   1      upstream offers in_data
//   in_ready    out  1      block accepts a word this cycle (combinational)
//   w           out  1      serial bit to the detector (registered)
//   w_valid     out  1      w carries a data bit, not the idle fill (registered)
//   busy        out  1      high in SHIFT or GAP state (registered)
//   frame_done  out  1      1-cycle pulse, high while the last bit of a word is on w
// BEHAVIOUR
//   Reset, asynchronous and immediate:
//     w=IDLE_LEVEL, w_valid=0, busy=0, frame_done=0, state=IDLE, counters=0.
//     in_ready is forced to 0 while rst is high.
//   States: IDLE, SHIFT, GAP. bit_cnt is $clog2(WIDTH) bits wide; gap_cnt is 8 bits wide.
//   Acceptance: occurs on any rising edge where in_valid && in_ready.
//   in_ready = IDLE
//            | (SHIFT && bit_cnt==WIDTH-1 && GAP_CYCLES==0)
//            | (GAP && gap_cnt==GAP_CYCLES-1)
//   IDLE:
//     On accept: load shreg, bit_cnt=0, go to SHIFT.
//     Otherwise: w=IDLE_LEVEL, w_valid=0.
//   SHIFT:
//     The cycle after acceptance shows the first bit on w with w_valid=1 (latency 1).
//     One bit per cycle for exactly WIDTH cycles, bit_cnt=0..WIDTH-1.
//   Last bit (bit_cnt==WIDTH-1), frame_done=1. Next state:
//     - SHIFT with the new word, if accepted this cycle (back-to-back, zero-bubble stream);
//     - else GAP, if GAP_CYCLES>0;
//     - else IDLE.
//   GAP:
//     w=IDLE_LEVEL, w_valid=0, busy=1 for exactly GAP_CYCLES cycles.
//     On the last gap cycle: accept → SHIFT, otherwise → IDLE.
//   in_data/in_valid changes without acceptance have no effect. A word is never re-sent.
//   Word accepted in IDLE at cycle t: bits on w at t+1..t+WIDTH; frame_done at t+WIDTH.
//   Reset mid-word: partial word is discarded; w returns to IDLE_LEVEL asynchronously.
//     The first word after reset release needs a fresh handshake.
//   Unreachable state encodings recover to IDLE on the next edge.
// STRUCTURE
//   Shared package: state encoding localparams (IDLE/SHIFT/GAP), default WIDTH.
//   Sub-module: piso_shreg, a WIDTH-bit parallel-load shift register.
//     Inputs: load, shift_en, MSB_FIRST parameter. Output: serial bit.
//   Top level holds the FSM, bit_cnt, gap_cnt and the output registers.
// TESTING
//   1. WIDTH=8, LSB-first, accept 8'h0F in IDLE
//      -> w=1,1,1,1,0,0,0,0 on cycles t+1..t+8; frame_done at t+8 only; w_valid low at t+9.
//   2. Back-to-back 8'h00 then 8'hFF, in_valid held high
//      -> 16 contiguous w_valid cycles, no bubble; in_ready high only on bit_cnt==7.
//      With the detector attached, its z goes high after the 4th zero and after the 4th one.
//   3. MSB_FIRST=1, word 8'hA5 -> w=1,0,1,0,0,1,0,1.
//   4. GAP_CYCLES=2, two words queued
//      -> exactly 2 cycles of w=IDLE_LEVEL with w_valid=0 and busy=1 between the words.
//   5. rst pulsed at bit 3 of 8'hC3
//      -> w=IDLE_LEVEL, w_valid=0 immediately; nothing further is sent;
//         next accepted word starts cleanly at bit 0.
//   6. in_valid low for 20 cycles while in_data toggles
//      -> w stays IDLE_LEVEL, w_valid=0, busy=0, in_ready=1 throughout.

Source files
------------

// File: rtl/serial_bit_feeder_pkg.sv
// Shared types and defaults for the serial bit feeder: FSM state encoding,
// default word width and counter widths.
package serial_bit_feeder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int GAP_CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/serial_bit_feeder_piso_shreg.sv
// Parallel-load shift register. On load it exposes the first bit of the incoming
// word and keeps the remaining bits; each shift exposes the following bit.
module serial_bit_feeder_piso_shreg
  import serial_bit_feeder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_load_bit,
  output logic             o_next_bit
);

  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_load_rest;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST) begin : g_msb
      assign o_load_bit  = i_data[WIDTH-1];
      assign w_load_rest = {i_data[WIDTH-2:0], 1'b0};
      assign w_shifted   = {r_shreg[WIDTH-2:0], 1'b0};
      assign o_next_bit  = r_shreg[WIDTH-1];
    end else begin : g_lsb
      assign o_load_bit  = i_data[0];
      assign w_load_rest = {1'b0, i_data[WIDTH-1:1]};
      assign w_shifted   = {1'b0, r_shreg[WIDTH-1:1]};
      assign o_next_bit  = r_shreg[0];
    end
  endgenerate

  // NOTE: the word register is reset too; a reset mid-word must not leave stale
  // bits that could leak onto w if the shift enable were ever mis-sequenced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= w_load_rest;
    end else if (i_shift_en) begin
      r_shreg <= w_shifted;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// drives them one bit per cycle onto w, with optional idle gaps between words.
module serial_bit_feeder
  import serial_bit_feeder_pkg::*;
#(
  parameter int          WIDTH      = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter logic        IDLE_LEVEL = 1'b0,
  parameter int unsigned GAP_CYCLES = 0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int                   BIT_CNT_W = $clog2(WIDTH);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WIDTH - 1);
  localparam bit                   HAS_GAP   = (GAP_CYCLES != 0);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP  = GAP_CNT_W'(GAP_CYCLES - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [BIT_CNT_W-1:0]   w_bit_cnt_nxt;
  logic [GAP_CNT_W-1:0]   r_gap_cnt;
  logic [GAP_CNT_W-1:0]   w_gap_cnt_nxt;
  logic                   r_w;
  logic                   r_w_valid;
  logic                   r_busy;
  logic                   r_frame_done;

  logic w_ready;
  logic w_accept;
  logic w_last_bit;
  logic w_last_gap;
  logic w_shift_en;
  logic w_load_bit;
  logic w_next_bit;
  logic w_bit_nxt;

  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  // Without a configured gap the GAP state is unreachable; treat it as already
  // finished so a corrupted state cannot linger there.
  assign w_last_gap = !HAS_GAP || (r_gap_cnt == LAST_GAP);

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case can infer a latch.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE:  w_ready = 1'b1;
      ST_SHIFT: w_ready = w_last_bit && !HAS_GAP;
      ST_GAP:   w_ready = w_last_gap;
      default:  w_ready = 1'b0;
    endcase
  end

  assign in_ready = w_ready && !rst;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt   = ST_IDLE;
    w_bit_cnt_nxt = '0;
    w_gap_cnt_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!w_last_bit) begin
          w_state_nxt   = ST_SHIFT;
          w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
        end else if (w_accept) begin
          w_state_nxt = ST_SHIFT;
        end else if (HAS_GAP) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!w_last_gap) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = r_gap_cnt + GAP_CNT_W'(1);
        end else if (w_accept) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_shift_en = (r_state == ST_SHIFT) && !w_last_bit;

  always_comb begin
    w_bit_nxt = IDLE_LEVEL;
    if (w_accept)        w_bit_nxt = w_load_bit;
    else if (w_shift_en) w_bit_nxt = w_next_bit;
  end

  serial_bit_feeder_piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso_shreg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_shift_en (w_shift_en),
    .i_data     (in_data),
    .o_load_bit (w_load_bit),
    .o_next_bit (w_next_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_w          <= IDLE_LEVEL;
      r_w_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_w          <= w_bit_nxt;
      r_w_valid    <= (w_state_nxt == ST_SHIFT);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= (w_state_nxt == ST_SHIFT) && (w_bit_cnt_nxt == LAST_BIT);
    end
  end

  assign w          = r_w;
  assign w_valid    = r_w_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder: two instances (LSB-first/no gap/idle 0 and
// MSB-first/2-cycle gap/idle 1) checked against a word-level timing model.
module tb_serial_bit_feeder;

  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic last;
  } exp_bit_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data   [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic       w         [2];
  logic       w_valid   [2];
  logic       busy      [2];
  logic       frame_done[2];
  logic       exp_ready [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  generate
    for (genvar g = 0; g < 2; g++) begin : gen_inst
      localparam bit   MSB = (g == 1);
      localparam int   GAP = 2 * g;
      localparam logic IDL = (g == 1);

      serial_bit_feeder #(
        .WIDTH      (W),
        .MSB_FIRST  (MSB),
        .IDLE_LEVEL (IDL),
        .GAP_CYCLES (GAP)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data[g]),
        .in_valid   (in_valid[g]),
        .in_ready   (in_ready[g]),
        .w          (w[g]),
        .w_valid    (w_valid[g]),
        .busy       (busy[g]),
        .frame_done (frame_done[g])
      );

      // Word-level model: a word accepted in cycle t occupies w for cycles t+1..t+W,
      // keeps the block busy through t+W+GAP, and the next word can be taken from
      // cycle t+W+GAP onward.
      int       cyc      = 0;
      int       last_acc = -100;
      int       free_at  = 0;
      exp_bit_t exp_q[$];

      assign exp_ready[g] = !rst && (cyc >= free_at);

      always @(posedge clk or posedge rst) begin
        if (rst) begin
          cyc      <= 0;
          last_acc <= -100;
          free_at  <= 0;
          exp_q.delete();
        end else begin
          cyc <= cyc + 1;
          if (in_valid[g] && exp_ready[g]) begin
            for (int i = 0; i < W; i++)
              exp_q.push_back('{b: in_data[g][MSB ? (W - 1 - i) : i], last: (i == W - 1)});
            last_acc <= cyc;
            free_at  <= cyc + W + GAP;
          end
        end
      end

      always @(negedge clk) begin : monitor
        exp_bit_t e;
        logic     ev;
        logic     eb;
        ev = (cyc > last_acc) && (cyc <= last_acc + W);
        eb = (cyc > last_acc) && (cyc <= last_acc + W + GAP);
        check_bit($sformatf("in_ready[%0d]", g), in_ready[g], exp_ready[g]);
        check_bit($sformatf("w_valid[%0d]", g), w_valid[g], ev);
        check_bit($sformatf("busy[%0d]", g), busy[g], eb);
        if (w_valid[g]) begin
          check_int($sformatf("sb_pending[%0d]", g), int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_bit($sformatf("w_bit[%0d]", g), w[g], e.b);
            check_bit($sformatf("frame_done[%0d]", g), frame_done[g], e.last);
          end
        end else begin
          check_bit($sformatf("w_idle[%0d]", g), w[g], IDL);
          check_bit($sformatf("frame_done_idle[%0d]", g), frame_done[g], 1'b0);
        end
      end
    end
  endgenerate

  // Offers one word and holds it until the model says the block takes it.
  task automatic send_word(input int g, input logic [7:0] d);
    int n;
    n = 0;
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    @(negedge clk);
    while (!exp_ready[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_int($sformatf("handshake_bound[%0d]", g), int'(n < 100), 1);
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_data[0] = 8'($urandom);
      in_data[1] = 8'($urandom);
    end
  endtask

  task automatic send_both(input logic [7:0] d);
    fork
      send_word(0, d);
      send_word(1, d);
    join
  endtask

  // Captures w over the W cycles following a simultaneous acceptance;
  // element k holds the bit seen k+1 cycles after the accepting edge.
  task automatic collect(output logic [7:0] s0, output logic [7:0] s1);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      s0[k] = w[0];
      s1[k] = w[1];
    end
  endtask

  task automatic random_stream(input int g, input int n_words);
    for (int n = 0; n < n_words; n++) begin
      int gap;
      gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      repeat (gap) begin
        in_data[g] = 8'($urandom);
        @(posedge clk);
        #1;
      end
      send_word(g, 8'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s0;
    logic [7:0] s1;

    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    in_data[0]  = 8'h00;
    in_data[1]  = 8'h00;
    #1 rst = 1'b1;
    #1;
    check_bit("reset_w0", w[0], 1'b0);
    check_bit("reset_w1", w[1], 1'b1);
    check_bit("reset_wvalid0", w_valid[0], 1'b0);
    check_bit("reset_busy1", busy[1], 1'b0);
    check_bit("reset_ready0", in_ready[0], 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Quiet input with toggling data: nothing may happen.
    idle_cycles(20);

    // Single word, checked against literal bit orders.
    send_both(8'h0F);
    collect(s0, s1);
    check_int("seq_lsb_0F", int'(s0), 8'h0F);
    check_int("seq_msb_0F", int'(s1), 8'hF0);
    idle_cycles(6);

    send_both(8'hA5);
    collect(s0, s1);
    check_int("seq_lsb_A5", int'(s0), 8'hA5);
    check_int("seq_msb_A5", int'(s1), 8'hA5);
    idle_cycles(6);

    // Back-to-back words with in_valid held high.
    fork
      begin send_word(0, 8'h00); send_word(0, 8'hFF); end
      begin send_word(1, 8'h00); send_word(1, 8'hFF); end
    join
    idle_cycles(14);

    // Reset while bit 3 of the word is on w.
    send_both(8'hC3);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_bit("midrst_w0", w[0], 1'b0);
    check_bit("midrst_w1", w[1], 1'b1);
    check_bit("midrst_wvalid0", w_valid[0], 1'b0);
    check_bit("midrst_wvalid1", w_valid[1], 1'b0);
    check_bit("midrst_busy0", busy[0], 1'b0);
    check_bit("midrst_ready1", in_ready[1], 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    idle_cycles(12);

    send_both(8'h3C);
    collect(s0, s1);
    check_int("post_rst_lsb_3C", int'(s0), 8'h3C);
    check_int("post_rst_msb_3C", int'(s1), 8'h3C);
    idle_cycles(6);

    // Randomised traffic on both instances.
    fork
      random_stream(0, 60);
      random_stream(1, 60);
    join
    idle_cycles(20);

    check_int("sb_drain0", gen_inst[0].exp_q.size(), 0);
    check_int("sb_drain1", gen_inst[1].exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
